vga_scan_controller: RTL
========================

// Module: vga_scan_controller
// PURPOSE
//   Parametrised VGA scan engine: generates sync/blank timing and fetches pixels from a
//   framebuffer RAM through an address/read-data port. Outputs 8-bit RGB to the DAC.
//   Adds configurable timing, integer pixel replication, RAM read latency and colour modes.
//   Sits in the top level between the shared video RAM read port and the board VGA pins.
// PARAMETERS
//   CLK_DIV    2    clk cycles per pixel tick; must be even, >= MEM_LAT+1
//   H_ACTIVE   640  visible pixels per line
//   H_FP       16   horizontal front porch, in pixels
//   H_SYNC     96   horizontal sync width, in pixels
//   H_BP       48   horizontal back porch, in pixels
//   V_ACTIVE   480  visible lines; V_FP 10, V_SYNC 2, V_BP 33 are the vertical porch/sync lines
//   SCALE_LOG2 2    each framebuffer pixel covers 2^S x 2^S screen pixels
//   ADDR_W     16   framebuffer address width
//   MEM_LAT    1    clk cycles from fb_addr change to valid fb_rdata
//   SYNC_POL   0    sync active level; 0 = active low
// PORTS
//   clk        in   1      system clock
//   reset      in   1      synchronous, active-high reset
//   enable     in   1      0 = force blank; timing keeps running
//   mode       in   1      0 = RGB332 colour, 1 = 8-bit greyscale; latched at frame start
//   fb_addr    out  ADDR_W framebuffer read address
//   fb_rdata   in   8      framebuffer read data
//   h_sync     out  1      horizontal sync
//   v_sync     out  1      vertical sync
//   red        out  8      red channel
//   green      out  8      green channel
//   blue       out  8      blue channel
//   clk_25MHz  out  1      pixel clock to DAC; high for the first CLK_DIV/2 cycles of each period
//   sync_n     out  1      composite sync to DAC; tied 0
//   blank_n    out  1      0 outside the active area or when blanked
//   frame_start out 1      one-clk pulse on the tick where counters wrap to (0,0)
// BEHAVIOUR
//   - Divider counts 0..CLK_DIV-1. Pixel tick = (div == CLK_DIV-1). All state advances on ticks only.
//   - Counters: h_cnt 0..H_TOT-1 (H_TOT = sum of H_*). v_cnt increments when h_cnt wraps.
//     v_cnt wraps to 0 after V_TOT-1.
//   - Active area: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
//   - Sync asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) and the same form vertically.
//   - fb_addr is registered on the tick: (v_cnt>>S)*(H_ACTIVE>>S) + (h_cnt>>S), truncated to ADDR_W.
//     It is 0 outside the active area.
//     Elaboration check: (H_ACTIVE>>S)*(V_ACTIVE>>S) <= 2^ADDR_W.
//   - fb_rdata is sampled at the next tick, CLK_DIV clk after the address is issued.
//     Colour, h_sync, v_sync and blank_n update on that same tick.
//     Result: outputs lag the counters by exactly one pixel period, and syncs are delayed to match.
//   - Colour, mode 0: red = {d[7:5],d[7:5],d[7:6]}, green = {d[4:2],d[4:2],d[4:3]}, blue = {4{d[1:0]}}.
//   - Colour, mode 1: red = green = blue = d.
//   - Outside active area or enable = 0: rgb = 0 and blank_n = 0. Syncs are unaffected.
//   - mode and enable are latched on the tick with h_cnt = v_cnt = 0.
//     Changes mid-frame take effect from the next frame only.
//   - Reset values: div, counters, fb_addr, rgb, frame_start, clk_25MHz and the mode latch are all 0.
//     blank_n = 0. h_sync and v_sync = !SYNC_POL. Enable latch = 0.
//   - Reset mid-frame: all outputs take reset values the next clk.
//     The scan restarts at (0,0) with a full divider period.
//   - The first frame_start is reported only after the first complete frame; there is none at reset release.
// STRUCTURE
//   vga_pkg holds:
//   - vga_timing_t struct (active/fp/sync/bp)
//   - colour_mode_e enum
//   - function rgb332_expand()
//   Sub-module vga_timing_gen holds the divider, h/v counters and sync/active decode.
//   The top holds the address generator, data capture, colour map and output alignment.
// TESTING (defaults unless stated)
//   1. Reset, then free-run: h_sync low for 96 ticks (192 clk) with period 800 ticks (1600 clk).
//      v_sync low for 2 lines (3200 clk).
//   2. frame_start pulses exactly every 420000 ticks (840000 clk), 1 clk wide.
//      clk_25MHz toggles every clk.
//   3. Pixel (h=7, v=9) -> fb_addr = 321. Pixel (639, 479) -> fb_addr = 19199.
//      In blanking -> fb_addr = 0.
//   4. RAM model, mode 0: fb_rdata 8'hE0 -> rgb FF/00/00; 8'h03 -> 00/00/FF.
//      Mode 1: 8'h5A -> 5A/5A/5A, aligned one pixel after its address.
//   5. Toggle mode at line 100 -> colours change only after the next frame_start.
//      enable = 0 -> blank_n = 0 and rgb = 0 while syncs keep their period.
//   6. Assert reset at h=300, v=200 -> next clk all outputs at reset values.
//      After release, h_sync first asserts at tick 657.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA scan engine: timing descriptor, colour modes
// and the RGB332 expansion used by the colour map.
package vga_pkg;

    typedef struct packed {
        logic [15:0] active;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
    } vga_timing_t;

    typedef enum logic {
        MODE_RGB332 = 1'b0,
        MODE_GREY   = 1'b1
    } colour_mode_e;

    function automatic int unsigned timing_total(input vga_timing_t t);
        return 32'(t.active) + 32'(t.fp) + 32'(t.sync) + 32'(t.bp);
    endfunction

    // Bit replication keeps full-scale codes at 8'hFF and zero at 8'h00.
    function automatic logic [23:0] rgb332_expand(input logic [7:0] d);
        return {d[7:5], d[7:5], d[7:6], d[4:2], d[4:2], d[4:3], {4{d[1:0]}}};
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-tick divider, horizontal/vertical scan counters and sync/active decode.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter vga_timing_t H_TIM   = '{16'd640, 16'd16, 16'd96, 16'd48},
    parameter vga_timing_t V_TIM   = '{16'd480, 16'd10, 16'd2, 16'd33},
    parameter int unsigned H_W     = 10,
    parameter int unsigned V_W     = 10
) (
    input  logic           clk,
    input  logic           reset,
    output logic           tick_c,
    output logic           pix_hi_nxt_c,
    output logic [H_W-1:0] h_nxt_c,
    output logic [V_W-1:0] v_nxt_c,
    output logic           active_c,
    output logic           h_sync_act_c,
    output logic           v_sync_act_c,
    output logic           origin_c,
    output logic           wrap_c
);

    localparam int unsigned H_TOT = timing_total(H_TIM);
    localparam int unsigned V_TOT = timing_total(V_TIM);
    localparam int unsigned H_SS  = 32'(H_TIM.active) + 32'(H_TIM.fp);
    localparam int unsigned H_SE  = H_SS + 32'(H_TIM.sync);
    localparam int unsigned V_SS  = 32'(V_TIM.active) + 32'(V_TIM.fp);
    localparam int unsigned V_SE  = V_SS + 32'(V_TIM.sync);
    localparam int unsigned DIV_W = $clog2(CLK_DIV);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nxt;
    logic [H_W-1:0]   h_cnt;
    logic [V_W-1:0]   v_cnt;
    logic             h_last;
    logic             v_last;

    assign tick_c = (div == DIV_W'(CLK_DIV - 1));
    assign h_last = (32'(h_cnt) == H_TOT - 1);
    assign v_last = (32'(v_cnt) == V_TOT - 1);

    // Next divider/counter values; counters only move on a pixel tick.
    always_comb begin
        div_nxt = tick_c ? '0 : div + DIV_W'(1);
        h_nxt_c = h_cnt;
        v_nxt_c = v_cnt;
        if (tick_c) begin
            if (h_last) begin
                h_nxt_c = '0;
                v_nxt_c = v_last ? '0 : v_cnt + V_W'(1);
            end else begin
                h_nxt_c = h_cnt + H_W'(1);
            end
        end
    end

    always_comb begin
        pix_hi_nxt_c = 32'(div_nxt) < (CLK_DIV / 2);
        active_c     = (32'(h_cnt) < 32'(H_TIM.active)) && (32'(v_cnt) < 32'(V_TIM.active));
        h_sync_act_c = (32'(h_cnt) >= H_SS) && (32'(h_cnt) < H_SE);
        v_sync_act_c = (32'(v_cnt) >= V_SS) && (32'(v_cnt) < V_SE);
        origin_c     = (h_cnt == '0) && (v_cnt == '0);
        wrap_c       = h_last && v_last;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div   <= '0;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            div   <= div_nxt;
            h_cnt <= h_nxt_c;
            v_cnt <= v_nxt_c;
        end
    end

endmodule

// File: rtl/vga_scan_controller.sv
// VGA scan engine top: framebuffer address generation, read-data capture, colour map
// and alignment of sync/blank with the pixel data one pixel period behind the counters.
module vga_scan_controller
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned SCALE_LOG2 = 2,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned MEM_LAT    = 1,
    parameter bit          SYNC_POL   = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              mode,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [7:0]        fb_rdata,
    output logic              h_sync,
    output logic              v_sync,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue,
    output logic              clk_25MHz,
    output logic              sync_n,
    output logic              blank_n,
    output logic              frame_start
);

    localparam vga_timing_t H_TIM = '{active: 16'(H_ACTIVE), fp: 16'(H_FP),
                                      sync: 16'(H_SYNC), bp: 16'(H_BP)};
    localparam vga_timing_t V_TIM = '{active: 16'(V_ACTIVE), fp: 16'(V_FP),
                                      sync: 16'(V_SYNC), bp: 16'(V_BP)};
    localparam int unsigned H_W   = $clog2(timing_total(H_TIM));
    localparam int unsigned V_W   = $clog2(timing_total(V_TIM));
    localparam int unsigned FB_W  = H_ACTIVE >> SCALE_LOG2;

    if ((CLK_DIV < 2) || (CLK_DIV % 2 != 0) || (CLK_DIV < MEM_LAT + 1)) begin : g_bad_div
        $error("vga_scan_controller: CLK_DIV must be even and at least MEM_LAT+1");
    end
    if (64'(FB_W) * 64'(V_ACTIVE >> SCALE_LOG2) > (64'd1 << ADDR_W)) begin : g_bad_addr
        $error("vga_scan_controller: framebuffer does not fit in ADDR_W bits");
    end

    logic              tick_c;
    logic              pix_hi_nxt_c;
    logic [H_W-1:0]    h_nxt_c;
    logic [V_W-1:0]    v_nxt_c;
    logic              active_c;
    logic              h_sync_act_c;
    logic              v_sync_act_c;
    logic              origin_c;
    logic              wrap_c;
    logic              nxt_active_c;
    logic              en_eff_c;
    logic              show_c;
    logic [ADDR_W-1:0] addr_c;
    logic [23:0]       colour_c;
    colour_mode_e      mode_q;
    colour_mode_e      mode_eff_c;
    logic              en_q;

    vga_timing_gen #(
        .CLK_DIV (CLK_DIV),
        .H_TIM   (H_TIM),
        .V_TIM   (V_TIM),
        .H_W     (H_W),
        .V_W     (V_W)
    ) u_timing (
        .clk          (clk),
        .reset        (reset),
        .tick_c       (tick_c),
        .pix_hi_nxt_c (pix_hi_nxt_c),
        .h_nxt_c      (h_nxt_c),
        .v_nxt_c      (v_nxt_c),
        .active_c     (active_c),
        .h_sync_act_c (h_sync_act_c),
        .v_sync_act_c (v_sync_act_c),
        .origin_c     (origin_c),
        .wrap_c       (wrap_c)
    );

    // Address follows the counters' new position; frame settings at (0,0) apply to that pixel too.
    always_comb begin
        nxt_active_c = (32'(h_nxt_c) < H_ACTIVE) && (32'(v_nxt_c) < V_ACTIVE);
        addr_c       = '0;
        if (nxt_active_c) begin
            addr_c = ADDR_W'((32'(v_nxt_c) >> SCALE_LOG2) * FB_W + (32'(h_nxt_c) >> SCALE_LOG2));
        end
        en_eff_c   = origin_c ? enable : en_q;
        mode_eff_c = origin_c ? colour_mode_e'(mode) : mode_q;
        show_c     = active_c && en_eff_c;
        colour_c   = (mode_eff_c == MODE_GREY) ? {3{fb_rdata}} : rgb332_expand(fb_rdata);
    end

    assign sync_n = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            fb_addr     <= '0;
            h_sync      <= ~SYNC_POL;
            v_sync      <= ~SYNC_POL;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            blank_n     <= 1'b0;
            frame_start <= 1'b0;
            clk_25MHz   <= 1'b0;
            mode_q      <= MODE_RGB332;
            en_q        <= 1'b0;
        end else begin
            frame_start <= tick_c && wrap_c;
            clk_25MHz   <= pix_hi_nxt_c;
            if (tick_c) begin
                fb_addr              <= addr_c;
                h_sync               <= h_sync_act_c ? SYNC_POL : ~SYNC_POL;
                v_sync               <= v_sync_act_c ? SYNC_POL : ~SYNC_POL;
                blank_n              <= show_c;
                {red, green, blue}   <= show_c ? colour_c : 24'h0;
                if (origin_c) begin
                    mode_q <= mode_eff_c;
                    en_q   <= en_eff_c;
                end
            end
        end
    end

endmodule
